// File: rtl/risc_pkg.sv
// Shared types and constants for the small RISC CPU and its memory responder.
package risc_pkg;

  localparam int AW_DEF = 5;
  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    READY = 2'd1,
    LOAD  = 2'd2
  } mem_state_t;

  localparam logic [2:0] HLT = 3'd0;
  localparam logic [2:0] SKZ = 3'd1;
  localparam logic [2:0] ADD = 3'd2;
  localparam logic [2:0] AND = 3'd3;
  localparam logic [2:0] XOR = 3'd4;
  localparam logic [2:0] LDA = 3'd5;
  localparam logic [2:0] STO = 3'd6;
  localparam logic [2:0] JMP = 3'd7;

  // Instruction word layout: opcode in the top three bits, operand address below.
  function automatic logic [7:0] mkInstr(input logic [2:0] op, input logic [4:0] operand);
    return {op, operand};
  endfunction

endpackage

// File: rtl/mem_array.sv
// DEPTH x DW register file with one synchronous write port and one registered read port.
module mem_array #(
  parameter int AW = 5,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_rdata;

  // Storage is deliberately not reset; the responder's CLEAR pass zeroes it.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/prog_mem_responder.sv
// CPU-side memory responder: clears storage after reset, serves CPU reads/writes,
// and accepts a streamed program image while the CPU is held in reset.
module prog_mem_responder
  import risc_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr,
  input  logic          rd,
  input  logic          wr,
  input  logic          data_e,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          rdata_valid,
  output logic          mem_busy,
  input  logic          load_en,
  input  logic          load_valid,
  input  logic [DW-1:0] load_data,
  output logic          load_ready,
  output logic          load_done,
  output logic          bus_err
);

  localparam logic [AW-1:0] LAST_ADDR = '1;

  mem_state_t    r_state;
  mem_state_t    w_stateNext;
  logic [AW-1:0] r_ptr;
  logic [AW-1:0] w_ptrNext;
  logic          r_reloadBlock;
  logic          w_reloadBlockNext;
  logic          r_loadDone;
  logic          w_loadDoneNext;
  logic          r_rdataValid;
  logic          r_busErr;
  logic          w_busy;
  logic          w_cpuRead;
  logic          w_err;
  logic          w_we;
  logic [AW-1:0] w_waddr;
  logic [DW-1:0] w_wdata;

  assign w_busy    = (r_state != READY);
  assign w_cpuRead = !w_busy && rd && !wr;
  assign w_err     = (w_busy && (rd || wr)) || (!w_busy && wr && (!data_e || rd));

  // Write-port arbitration between CLEAR, LOAD and CPU plus next-state logic.
  // A load that ends on the last word blocks re-entry until load_en drops.
  always_comb begin
    w_stateNext       = r_state;
    w_ptrNext         = r_ptr;
    w_loadDoneNext    = 1'b0;
    w_reloadBlockNext = load_en ? r_reloadBlock : 1'b0;
    w_we              = 1'b0;
    w_waddr           = r_ptr;
    w_wdata           = '0;
    case (r_state)
      CLEAR: begin
        w_we      = 1'b1;
        w_ptrNext = r_ptr + 1'b1;
        if (r_ptr == LAST_ADDR) begin
          w_stateNext = READY;
        end
      end
      READY: begin
        if (wr && data_e) begin
          w_we    = 1'b1;
          w_waddr = addr;
          w_wdata = wdata;
        end
        if (load_en && !r_reloadBlock) begin
          w_stateNext = LOAD;
          w_ptrNext   = '0;
        end
      end
      LOAD: begin
        if (!load_en) begin
          w_stateNext    = READY;
          w_loadDoneNext = 1'b1;
        end else if (load_valid) begin
          w_we      = 1'b1;
          w_wdata   = load_data;
          w_ptrNext = r_ptr + 1'b1;
          if (r_ptr == LAST_ADDR) begin
            w_stateNext       = READY;
            w_loadDoneNext    = 1'b1;
            w_reloadBlockNext = 1'b1;
          end
        end
      end
      default: begin
        w_stateNext = CLEAR;
        w_ptrNext   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= CLEAR;
      r_ptr         <= '0;
      r_reloadBlock <= 1'b0;
      r_loadDone    <= 1'b0;
      r_rdataValid  <= 1'b0;
      r_busErr      <= 1'b0;
    end else begin
      r_state       <= w_stateNext;
      r_ptr         <= w_ptrNext;
      r_reloadBlock <= w_reloadBlockNext;
      r_loadDone    <= w_loadDoneNext;
      r_rdataValid  <= w_cpuRead;
      r_busErr      <= r_busErr | w_err;
    end
  end

  mem_array #(
    .AW(AW),
    .DW(DW)
  ) u_mem (
    .clk    (clk),
    .rst    (rst),
    .i_we   (w_we && !rst),
    .i_waddr(w_waddr),
    .i_wdata(w_wdata),
    .i_re   (w_cpuRead),
    .i_raddr(addr),
    .o_rdata(rdata)
  );

  assign rdata_valid = r_rdataValid;
  assign mem_busy    = w_busy;
  assign load_ready  = (r_state == LOAD);
  assign load_done   = r_loadDone;
  assign bus_err     = r_busErr;

endmodule

// File: tb/tb_prog_mem_responder.sv
// Self-checking bench for prog_mem_responder: directed load/reset sequences,
// a CPU access vector table, and random CPU traffic against a memory model.
module tb_prog_mem_responder;
  import risc_pkg::*;

  localparam int DEPTH = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] addr;
  logic       rd, wr, data_e;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       rdata_valid, mem_busy;
  logic       load_en, load_valid;
  logic [7:0] load_data;
  logic       load_ready, load_done, bus_err;

  int assertCount = 0;
  int failCount   = 0;

  logic [7:0] mdlMem [DEPTH];
  logic [7:0] mdlRdata;
  logic       mdlErr;

  typedef struct {
    logic       rd;
    logic       wr;
    logic       de;
    logic [4:0] addr;
    logic [7:0] wdata;
    logic       expValid;
    logic [7:0] expRdata;
    logic       expErr;
  } vec_t;

  vec_t vecs [14];

  prog_mem_responder #(.AW(5), .DW(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .rd         (rd),
    .wr         (wr),
    .data_e     (data_e),
    .wdata      (wdata),
    .rdata      (rdata),
    .rdata_valid(rdata_valid),
    .mem_busy   (mem_busy),
    .load_en    (load_en),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .load_done  (load_done),
    .bus_err    (bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic iRd, input logic iWr, input logic iDe,
                               input logic [4:0] iAddr, input logic [7:0] iWdata);
    rd     = iRd;
    wr     = iWr;
    data_e = iDe;
    addr   = iAddr;
    wdata  = iWdata;
  endtask

  task automatic doReset();
    int busyCount;
    int doneCount;
    rst        = 1'b1;
    load_en    = 1'b0;
    load_valid = 1'b0;
    load_data  = 8'h00;
    applyStimulus(0, 0, 0, 5'd0, 8'h00);
    tick();
    tick();
    checkOutput("reset rdata", 32'(rdata), 32'h0);
    checkOutput("reset rdata_valid", 32'(rdata_valid), 32'h0);
    checkOutput("reset mem_busy", 32'(mem_busy), 32'h1);
    checkOutput("reset load_ready", 32'(load_ready), 32'h0);
    checkOutput("reset load_done", 32'(load_done), 32'h0);
    checkOutput("reset bus_err", 32'(bus_err), 32'h0);
    rst       = 1'b0;
    busyCount = 0;
    doneCount = 0;
    for (int i = 0; i < 40; i++) begin
      if (mem_busy) busyCount++;
      tick();
      if (load_done) doneCount++;
    end
    checkOutput("clear busy cycles", 32'(busyCount), 32'd32);
    checkOutput("clear load_done pulses", 32'(doneCount), 32'd0);
    checkOutput("clear bus_err", 32'(bus_err), 32'h0);
    for (int i = 0; i < DEPTH; i++) mdlMem[i] = 8'h00;
    mdlRdata = 8'h00;
    mdlErr   = 1'b0;
  endtask

  task automatic cpuReadCheck(input string name, input int a);
    applyStimulus(1, 0, 0, 5'(a), 8'h00);
    tick();
    checkOutput({name, " valid"}, 32'(rdata_valid), 32'h1);
    checkOutput({name, " data"}, 32'(rdata), 32'(mdlMem[a]));
    mdlRdata = mdlMem[a];
    applyStimulus(0, 0, 0, 5'd0, 8'h00);
  endtask

  task automatic readAll(input string name);
    for (int i = 0; i < DEPTH; i++) cpuReadCheck(name, i);
  endtask

  initial begin
    int b;
    int guard;
    int stallLeft;
    int doneCount;
    logic accepted;
    logic expValid;
    logic iRd, iWr, iDe;
    logic [4:0] iAddr;
    logic [7:0] iWdata;

    //                 rd wr de addr   wdata  valid rdata  err
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 5'h00, 8'h00, 1'b1, 8'h11, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 5'h07, 8'h5C, 1'b0, 8'h11, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 5'h07, 8'h00, 1'b1, 8'h5C, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 5'h00, 8'h00, 1'b0, 8'h5C, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 5'h00, 8'h00, 1'b0, 8'h5C, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 5'h00, 8'h00, 1'b0, 8'h5C, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 5'h00, 8'h00, 1'b0, 8'h5C, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 5'h07, 8'h00, 1'b0, 8'h5C, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 5'h07, 8'h00, 1'b1, 8'h5C, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 5'h03, 8'hFF, 1'b0, 8'h5C, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 5'h03, 8'h00, 1'b1, 8'h14, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 5'h09, 8'h3C, 1'b0, 8'h14, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 5'h09, 8'h00, 1'b1, 8'h3C, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 5'h00, 8'h00, 1'b0, 8'h3C, 1'b1};

    doReset();
    readAll("cleared read");

    // Full 32-byte load with a three-cycle stall and one illegal read while busy.
    load_en = 1'b1;
    tick();
    checkOutput("load entry load_ready", 32'(load_ready), 32'h1);
    checkOutput("load entry mem_busy", 32'(mem_busy), 32'h1);
    b         = 0;
    guard     = 0;
    stallLeft = 3;
    doneCount = 0;
    while (b < DEPTH && guard < 100) begin
      guard++;
      if (b == 10 && stallLeft > 0) begin
        load_valid = 1'b0;
        if (stallLeft == 3) applyStimulus(1, 0, 0, 5'h1F, 8'h00);
        stallLeft--;
      end else begin
        load_valid = 1'b1;
        load_data  = 8'(b + 'hA0);
        checkOutput("load_ready before accept", 32'(load_ready), 32'h1);
      end
      accepted = load_valid && load_ready;
      tick();
      if (load_done) doneCount++;
      if (rd) begin
        checkOutput("busy read valid", 32'(rdata_valid), 32'h0);
        checkOutput("busy read rdata", 32'(rdata), 32'(mdlRdata));
        checkOutput("busy read bus_err", 32'(bus_err), 32'h1);
        mdlErr = 1'b1;
        applyStimulus(0, 0, 0, 5'd0, 8'h00);
      end
      if (accepted) begin
        mdlMem[b] = 8'(b + 'hA0);
        b++;
      end
    end
    checkOutput("full load bytes accepted", 32'(b), 32'd32);
    load_valid = 1'b0;
    checkOutput("full load exit load_ready", 32'(load_ready), 32'h0);
    checkOutput("full load exit mem_busy", 32'(mem_busy), 32'h0);
    load_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (load_done) doneCount++;
    end
    checkOutput("full load done pulses", 32'(doneCount), 32'd1);
    applyStimulus(1, 0, 0, 5'h1F, 8'h00);
    tick();
    checkOutput("read 0x1F after load", 32'(rdata), 32'hBF);
    applyStimulus(0, 0, 0, 5'd0, 8'h00);
    readAll("loaded read");

    // Partial load: five bytes, then load_en drops with a byte still offered.
    doReset();
    load_en   = 1'b1;
    tick();
    doneCount = 0;
    for (int k = 0; k < 5; k++) begin
      load_valid = 1'b1;
      load_data  = 8'(8'h11 + k);
      tick();
      if (load_done) doneCount++;
      mdlMem[k] = 8'(8'h11 + k);
    end
    load_en    = 1'b0;
    load_data  = 8'h99;
    tick();
    if (load_done) doneCount++;
    checkOutput("partial exit load_done", 32'(load_done), 32'h1);
    checkOutput("partial exit load_ready", 32'(load_ready), 32'h0);
    checkOutput("partial exit mem_busy", 32'(mem_busy), 32'h0);
    load_valid = 1'b0;
    tick();
    if (load_done) doneCount++;
    checkOutput("partial done pulses", 32'(doneCount), 32'd1);
    for (int i = 0; i < 6; i++) cpuReadCheck("partial read", i);
    checkOutput("partial mem[5] zero", 32'(mdlRdata), 32'h00);

    // Table-driven CPU access sequence.
    for (int v = 0; v < 14; v++) begin
      applyStimulus(vecs[v].rd, vecs[v].wr, vecs[v].de, vecs[v].addr, vecs[v].wdata);
      tick();
      checkOutput($sformatf("vec%0d rdata_valid", v), 32'(rdata_valid), 32'(vecs[v].expValid));
      checkOutput($sformatf("vec%0d rdata", v), 32'(rdata), 32'(vecs[v].expRdata));
      checkOutput($sformatf("vec%0d bus_err", v), 32'(bus_err), 32'(vecs[v].expErr));
    end
    applyStimulus(0, 0, 0, 5'd0, 8'h00);

    // Reset in the middle of a load must restart the clear pass.
    load_en = 1'b1;
    tick();
    for (int k = 0; k < 10; k++) begin
      load_valid = 1'b1;
      load_data  = mkInstr(LDA, 5'(k));
      tick();
    end
    checkOutput("mid-load still loading", 32'(load_ready), 32'h1);
    doReset();
    readAll("post-abort read");

    // Random CPU traffic against the memory model.
    for (int i = 0; i < 300; i++) begin
      if (i == 150) doReset();
      iRd    = 1'($urandom_range(0, 1));
      iWr    = ($urandom_range(0, 3) == 0);
      iDe    = ($urandom_range(0, 4) != 0);
      iAddr  = 5'($urandom);
      iWdata = 8'($urandom);
      expValid = iRd && !iWr;
      if (expValid) mdlRdata = mdlMem[iAddr];
      if (iWr && (!iDe || iRd)) mdlErr = 1'b1;
      if (iWr && iDe) mdlMem[iAddr] = iWdata;
      applyStimulus(iRd, iWr, iDe, iAddr, iWdata);
      tick();
      checkOutput("random rdata_valid", 32'(rdata_valid), 32'(expValid));
      checkOutput("random rdata", 32'(rdata), 32'(mdlRdata));
      checkOutput("random bus_err", 32'(bus_err), 32'(mdlErr));
    end
    applyStimulus(0, 0, 0, 5'd0, 8'h00);
    readAll("random final read");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
